normalizer: RTL and testbench

//  Iterative left-normalizer: finds the leading-zero count of a 32-bit word and returns the word shifted left so its MSB is set.

---
 rtl/normalizer_pkg.sv | 19 +
 rtl/mux2.sv | 20 ++
 rtl/normalizer.sv | 128 ++++++++++++
 tb/tb_normalizer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/normalizer_pkg.sv
// ---------------------------------------------------------------------------
// normalizer_pkg
// Shared definitions for the iterative left-normalizer.
//   state_t       : FSM state type (IDLE waits for a request, SEARCH runs
//                   one binary stage per cycle)
//   WIDTH_DEFAULT : default data width
//   NUM_STAGES    : number of binary search stages for the default width
// ---------------------------------------------------------------------------
package normalizer_pkg;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_SEARCH = 1'b1
  } state_t;

  localparam int WIDTH_DEFAULT = 32;
  localparam int NUM_STAGES    = $clog2(WIDTH_DEFAULT);

endpackage

// File: rtl/mux2.sv
// ---------------------------------------------------------------------------
// mux2
// Generic two-input multiplexer cell.
//   sel : 0 selects a, 1 selects b
//   a   : input 0 (BITS wide)
//   b   : input 1 (BITS wide)
//   y   : selected output (BITS wide)
// ---------------------------------------------------------------------------
module mux2 #(
  parameter int BITS = 1
) (
  input  logic            sel,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic [BITS-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/normalizer.sv
// ---------------------------------------------------------------------------
// normalizer
// Iterative left-normalizer. Finds the leading-zero count of the operand and
// returns the operand shifted left so that its MSB is set. Searches one
// binary stage per cycle, largest step first (WIDTH/2 down to 1), so
// out == in << amount when done pulses.
//   clk     : clock, rising edge
//   reset   : asynchronous, active-high reset
//   start   : request, sampled only while busy is low
//   in      : operand, sampled with an accepted start
//   busy    : search in progress
//   done    : one-cycle pulse, results valid
//   out     : normalized value
//   amount  : leading-zero count, 0..WIDTH
//   is_zero : operand was zero
// ---------------------------------------------------------------------------
module normalizer
  import normalizer_pkg::*;
#(
  parameter  int WIDTH    = WIDTH_DEFAULT,
  localparam int AMT_BITS = $clog2(WIDTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDTH-1:0]    in,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    out,
  output logic [AMT_BITS-1:0] amount,
  output logic                is_zero
);

  localparam int STAGES = $clog2(WIDTH);
  localparam int K_BITS = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [K_BITS-1:0] LAST_K = K_BITS'(STAGES - 1);

  state_t              state;
  logic [K_BITS-1:0]   k;
  logic [WIDTH-1:0]    shreg;
  logic [WIDTH-1:0]    shreg_shifted;
  logic [WIDTH-1:0]    shreg_next;
  logic [AMT_BITS-1:0] amount_q;
  logic                done_q;
  logic                is_zero_q;
  logic                top_zero;

  // Step size of stage kk is 2^kk bits.
  function automatic logic [WIDTH-1:0] shl_pow2(input logic [WIDTH-1:0] d,
                                                input logic [K_BITS-1:0] kk);
    return d << (32'd1 << kk);
  endfunction

  // True when the top 2^kk bits of d are all zero.
  function automatic logic top_bits_zero(input logic [WIDTH-1:0] d,
                                         input logic [K_BITS-1:0] kk);
    logic [31:0] step;
    step = 32'd1 << kk;
    return (d >> (32'(WIDTH) - step)) == '0;
  endfunction

  assign shreg_shifted = shl_pow2(shreg, k);
  assign top_zero      = top_bits_zero(shreg, k);

  // Each stage either keeps the register or takes the shifted copy.
  mux2 #(
    .BITS(WIDTH)
  ) u_stage_mux (
    .sel(top_zero),
    .a  (shreg),
    .b  (shreg_shifted),
    .y  (shreg_next)
  );

  // A zero operand skips the search entirely and reports in one cycle. A
  // nonzero operand walks k from the largest stage down to 0; each stage that
  // shifts records its weight in amount, which builds the count bit by bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      k         <= '0;
      shreg     <= '0;
      amount_q  <= '0;
      done_q    <= 1'b0;
      is_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (in == '0) begin
              shreg     <= '0;
              amount_q  <= AMT_BITS'(WIDTH);
              is_zero_q <= 1'b1;
              done_q    <= 1'b1;
            end else begin
              shreg     <= in;
              amount_q  <= '0;
              is_zero_q <= 1'b0;
              k         <= LAST_K;
              state     <= S_SEARCH;
            end
          end
        end
        S_SEARCH: begin
          shreg <= shreg_next;
          if (top_zero) begin
            amount_q[k] <= 1'b1;
          end
          if (k == '0) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end else begin
            k <= k - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy    = (state == S_SEARCH);
  assign done    = done_q;
  assign out     = shreg;
  assign amount  = amount_q;
  assign is_zero = is_zero_q;

endmodule

// File: tb/tb_normalizer.sv
// ---------------------------------------------------------------------------
// tb_normalizer
// Self-checking bench for normalizer. The driver pushes the expected result
// of each request into a queue; the monitor pops and compares whenever done
// is seen.
// ---------------------------------------------------------------------------
module tb_normalizer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] in;
  logic        busy;
  logic        done;
  logic [31:0] out;
  logic [5:0]  amount;
  logic        is_zero;

  typedef struct {
    logic [31:0] op;
    logic [31:0] exp_out;
    int          exp_amt;
    logic        exp_zero;
    int          exp_cycle;
  } expect_t;

  expect_t sb_q[$];
  int      cycle = 0;
  int      total = 0;
  int      bad   = 0;

  normalizer dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .in     (in),
    .busy   (busy),
    .done   (done),
    .out    (out),
    .amount (amount),
    .is_zero(is_zero)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts rising edges so latencies can be expressed in cycles.
  always @(posedge clk) cycle++;

  // Single comparison point for both the driver and the monitor.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
               name, actual, expected, cycle);
    end
  endtask

  task automatic pushExpect(input logic [31:0] op, input logic [31:0] exp_out,
                            input int exp_amt, input logic exp_zero,
                            input int lat);
    expect_t e;
    e.op        = op;
    e.exp_out   = exp_out;
    e.exp_amt   = exp_amt;
    e.exp_zero  = exp_zero;
    e.exp_cycle = cycle + lat;
    sb_q.push_back(e);
  endtask

  // Issues one request just after a rising edge and returns in the cycle its
  // done pulse is expected, so the next call lands in the done cycle.
  task automatic applyStimulus(input logic [31:0] op, input logic [31:0] exp_out,
                               input int exp_amt, input logic exp_zero,
                               input int lat);
    start = 1'b1;
    in    = op;
    pushExpect(op, exp_out, exp_amt, exp_zero, lat);
    @(posedge clk);
    #1;
    start = 1'b0;
    in    = '0;
    for (int i = 1; i < lat; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)",
                 cycle);
      end else begin
        expect_t e;
        e = sb_q.pop_front();
        checkOutput("out", out, e.exp_out);
        checkOutput("amount", 32'(amount), 32'(e.exp_amt));
        checkOutput("is_zero", 32'(is_zero), 32'(e.exp_zero));
        checkOutput("latency", 32'(cycle), 32'(e.exp_cycle));
        if (!e.exp_zero) begin
          checkOutput("msb_set", 32'(out[31]), 32'd1);
          checkOutput("shift_back", out >> amount, e.op);
        end
      end
    end
  end

  // Hard stop in case something wedges the main sequence.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] op;
    int          lz;

    reset = 1'b1;
    start = 1'b0;
    in    = '0;
    #2;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_out", out, 32'd0);
    checkOutput("reset_amount", 32'(amount), 32'd0);
    checkOutput("reset_is_zero", 32'(is_zero), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] directed vectors");
    start = 1'b1;
    in    = 32'h0000_0001;
    pushExpect(32'h0000_0001, 32'h8000_0000, 31, 1'b0, 6);
    @(posedge clk);
    #1;
    start = 1'b0;
    in    = '0;
    checkOutput("busy_mid", 32'(busy), 32'd1);
    for (int i = 1; i < 6; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("busy_after", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("hold_out", out, 32'h8000_0000);
    checkOutput("hold_amount", 32'(amount), 32'd31);

    applyStimulus(32'h8000_0000, 32'h8000_0000, 0, 1'b0, 6);
    applyStimulus(32'h0000_0000, 32'h0000_0000, 32, 1'b1, 1);
    checkOutput("zero_busy", 32'(busy), 32'd0);
    applyStimulus(32'h0001_2345, 32'h91A2_8000, 15, 1'b0, 6);

    // Start while busy must be ignored and the operand kept.
    start = 1'b1;
    in    = 32'h00FF_0000;
    pushExpect(32'h00FF_0000, 32'hFF00_0000, 8, 1'b0, 6);
    @(posedge clk);
    #1;
    start = 1'b0;
    in    = '0;
    @(posedge clk);
    #1;
    start = 1'b1;
    in    = 32'h0000_0001;
    @(posedge clk);
    #1;
    start = 1'b0;
    in    = '0;
    for (int i = 3; i < 6; i++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;

    // Reset in the middle of a search: no done pulse, outputs cleared.
    start = 1'b1;
    in    = 32'h0000_0010;
    @(posedge clk);
    #1;
    start = 1'b0;
    in    = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_out", out, 32'd0);
    checkOutput("abort_amount", 32'(amount), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
    end
    applyStimulus(32'h0000_0010, 32'h8000_0000, 27, 1'b0, 6);

    $display("[TB] back-to-back random operands");
    for (int n = 0; n < 10000; n++) begin
      lz = int'($urandom_range(0, 31));
      op = ($urandom() | 32'h8000_0000) >> lz;
      applyStimulus(op, op << lz, lz, 1'b0, 6);
    end

    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("pending", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
